// File: rtl/yutorina_bus_master_if_pkg.sv
// Shared definitions for the bus master interface: FSM state encoding and bus polarities.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package yutorina_bus_master_if_pkg;

    // Width of the bus interface state register.
    localparam int BUS_IF_STATE_W = 2;

    // Bus master interface FSM states.
    typedef enum logic [BUS_IF_STATE_W-1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_t;

    // Direction encoding on bus_rw.
    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    // Active-low bus control levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Reset is active-high.
    localparam logic RESET_ENABLE = 1'b1;

endpackage

// File: rtl/yutorina_bus_master_if.sv
// Bus master interface: issues one pipeline load/store as a single req/grant + strobe/ready bus transaction.
// Latency: 3 cycles minimum (request, strobe, ready) with a parked grant; +1 per cycle of grant or ready wait.
// Backpressure: busy stalls the pipeline until ready; pipeline stall holds the read result in STALL.
module yutorina_bus_master_if
    import yutorina_bus_master_if_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              req_access,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    bus_if_state_t     state;
    logic [DATA_W-1:0] rd_data_q;

    // Transaction FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst == RESET_ENABLE) begin
            state       <= BUS_IF_STATE_IDLE;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_addr    <= '0;
            bus_rw      <= BUS_READ;
            bus_wr_data <= '0;
            rd_data_q   <= '0;
        end else begin
            unique case (state)
                BUS_IF_STATE_IDLE: begin
                    // Latch the request so the bus sees stable values even if the pipeline moves on.
                    if (req_access && !flush) begin
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                        bus_req_    <= ENABLE_;
                        state       <= BUS_IF_STATE_REQ;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    // A flush can still cancel here because nothing is on the bus yet.
                    if (flush) begin
                        bus_req_ <= DISABLE_;
                        state    <= BUS_IF_STATE_IDLE;
                    end else if (bus_grnt_ == ENABLE_) begin
                        bus_as_ <= ENABLE_;
                        state   <= BUS_IF_STATE_ACCESS;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    // Strobe is a single-cycle pulse; the request is held until the slave answers.
                    // Flush is deliberately ignored: the slave transaction must complete.
                    bus_as_ <= DISABLE_;
                    if (bus_rdy_ == ENABLE_) begin
                        rd_data_q <= bus_rd_data;
                        bus_req_  <= DISABLE_;
                        state     <= stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    end
                end
                BUS_IF_STATE_STALL: begin
                    // Hold the result and never re-issue while the pipeline is frozen.
                    if (!stall) begin
                        state <= BUS_IF_STATE_IDLE;
                    end
                end
                default: begin
                    state <= BUS_IF_STATE_IDLE;
                end
            endcase
        end
    end

    // Stall request to the pipeline and read data bypass in the ready cycle.
    always_comb begin
        busy    = 1'b0;
        rd_data = rd_data_q;
        unique case (state)
            BUS_IF_STATE_IDLE:   busy = req_access && !flush;
            BUS_IF_STATE_REQ:    busy = !flush;
            BUS_IF_STATE_ACCESS: begin
                busy = (bus_rdy_ == DISABLE_);
                if (bus_rdy_ == ENABLE_) begin
                    rd_data = bus_rd_data;
                end
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Self-checking bench for yutorina_bus_master_if: arbiter and slave models plus a strobe/read-data scoreboard.
// Latency: n/a.
// Backpressure: the bench pipeline honours busy and holds its request until busy drops.
module tb_yutorina_bus_master_if;
    import yutorina_bus_master_if_pkg::*;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              req_access;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              bus_req_;
    logic              bus_grnt_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;

    yutorina_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .req_access  (req_access),
        .addr        (addr),
        .rw          (rw),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected bus transactions (checked at the strobe) and expected read data (checked at ready).
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic              r;
        logic [DATA_W-1:0] d;
    } exp_t;
    exp_t              sb_q[$];
    logic [DATA_W-1:0] rd_q[$];

    // Arbiter and slave model knobs, set by the driver before each transaction.
    bit                park   = 1'b0;
    int                gdelay = 1;
    int                rdelay = 0;
    logic [DATA_W-1:0] slave_data = '0;
    logic [DATA_W-1:0] last_rd = '0;

    // Arbiter model: parked grant, or grant after gdelay cycles of request; held while request is low.
    initial begin
        int rcnt;
        rcnt = 0;
        bus_grnt_ = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bus_req_ == 1'b0) rcnt++;
            else rcnt = 0;
            bus_grnt_ = (park || (bus_req_ == 1'b0 && rcnt > gdelay)) ? 1'b0 : 1'b1;
        end
    end

    // Slave model: answers rdelay cycles after the strobe; drives noise on the data bus otherwise.
    initial begin
        bit active;
        int cnt;
        active = 1'b0;
        cnt = 0;
        bus_rdy_ = 1'b1;
        bus_rd_data = '0;
        forever begin
            @(posedge clk); #1;
            bus_rdy_ = 1'b1;
            bus_rd_data = $urandom;
            if (active && bus_req_ == 1'b1) active = 1'b0;
            if (!active && bus_as_ == 1'b0) begin
                active = 1'b1;
                cnt = rdelay;
            end
            if (active) begin
                if (cnt == 0) begin
                    bus_rdy_ = 1'b0;
                    bus_rd_data = slave_data;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: compares each strobe and each ready cycle against the scoreboard queues.
    bit prev_as_low = 1'b0;
    bit prev_grant  = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_as_ == 1'b0) begin
                chk("strobe_single_cycle", {63'd0, prev_as_low}, 64'd0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("strobe_addr", {34'd0, bus_addr}, {34'd0, e.a});
                    chk("strobe_rw", {63'd0, bus_rw}, {63'd0, e.r});
                    chk("strobe_wdata", {32'd0, bus_wr_data}, {32'd0, e.d});
                end
            end
            if (bus_rdy_ == 1'b0) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    logic [DATA_W-1:0] ed;
                    ed = rd_q.pop_front();
                    chk("ready_rd_data", {32'd0, rd_data}, {32'd0, ed});
                    chk("ready_busy_low", {63'd0, busy}, 64'd0);
                end
            end
            assert (!(prev_grant && bus_req_ == 1'b0 && bus_grnt_ == 1'b1))
                else $error("grant dropped while request held");
        end
        prev_as_low = !rst && (bus_as_ == 1'b0);
        prev_grant  = (bus_req_ == 1'b0) && (bus_grnt_ == 1'b0);
    end

    // One pipeline access. t_gd = 0 means parked grant; t_fl: 0 none, 1 flush in REQ, 2 flush in ACCESS.
    task automatic run_txn(input logic t_rw, input logic [ADDR_W-1:0] t_addr, input logic [DATA_W-1:0] t_wd,
                           input logic [DATA_W-1:0] t_rd, input int t_gd, input int t_rdl, input int t_st,
                           input int t_fl);
        int n;
        int as_cyc;
        bit done;
        park = (t_gd == 0);
        gdelay = t_gd;
        rdelay = t_rdl;
        slave_data = t_rd;
        if (t_fl != 1) begin
            sb_q.push_back('{a: t_addr, r: t_rw, d: t_wd});
            rd_q.push_back(t_rd);
        end
        @(posedge clk); #1;
        req_access = 1'b1;
        rw = t_rw;
        addr = t_addr;
        wr_data = t_wd;
        stall = (t_st > 0);
        flush = 1'b0;
        n = 0;
        as_cyc = -1;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            if (n == 0) chk("busy_on_request", {63'd0, busy}, 64'd1);
            if (n >= 1) begin
                chk("req_held_low", {63'd0, bus_req_}, 64'd0);
                chk("addr_stable", {34'd0, bus_addr}, {34'd0, t_addr});
                chk("wdata_stable", {32'd0, bus_wr_data}, {32'd0, t_wd});
            end
            if (bus_as_ == 1'b0 && as_cyc < 0) as_cyc = n;
            if (busy == 1'b0) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (t_fl == 1 && n == 1) flush = 1'b1;
                if (t_fl == 2 && as_cyc >= 0) flush = 1'b1;
                n++;
            end
        end
        if (!done) chk("access_timeout", 64'd1, 64'd0);
        if (t_fl == 1) begin
            chk("flush_no_strobe", {63'd0, as_cyc < 0}, 64'd1);
            chk("flush_busy_cycle", n, 2);
        end else begin
            chk("strobe_cycle", as_cyc, (t_gd == 0) ? 2 : t_gd + 2);
            chk("ready_cycle", n, ((t_gd == 0) ? 2 : t_gd + 2) + t_rdl);
            last_rd = t_rd;
        end
        @(posedge clk); #1;
        if (t_st > 0 && t_fl != 1) begin
            for (int k = 0; k < t_st; k++) begin
                @(negedge clk);
                chk("stall_busy_low", {63'd0, busy}, 64'd0);
                chk("stall_rd_hold", {32'd0, rd_data}, {32'd0, last_rd});
                chk("stall_no_reissue", {63'd0, bus_req_}, 64'd1);
                @(posedge clk); #1;
            end
            stall = 1'b0;
            @(negedge clk);
            chk("stall_exit_no_reissue", {63'd0, bus_req_}, 64'd1);
            @(posedge clk); #1;
        end
        req_access = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("req_released", {63'd0, bus_req_}, 64'd1);
        chk("rd_data_held", {32'd0, rd_data}, {32'd0, last_rd});
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        req_access = 1'b0;
        addr = '0;
        rw = BUS_READ;
        wr_data = '0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_bus_req", {63'd0, bus_req_}, 64'd1);
        chk("rst_bus_as", {63'd0, bus_as_}, 64'd1);
        chk("rst_bus_addr", {34'd0, bus_addr}, 64'd0);
        chk("rst_bus_rw", {63'd0, bus_rw}, 64'd1);
        chk("rst_bus_wdata", {32'd0, bus_wr_data}, 64'd0);
        chk("rst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Read with parked grant, slave answers the cycle after the strobe.
        run_txn(BUS_READ, 30'h0000100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0);
        // Write under contention, grant four cycles late.
        run_txn(BUS_WRITE, 30'h0ABCDE0, 32'h12345678, 32'h0BADF00D, 4, 2, 0, 0);
        // Flush before the grant: nothing reaches the bus.
        run_txn(BUS_READ, 30'h0000200, 32'h0, 32'h11112222, 3, 0, 0, 1);
        // Flush once the strobe is out: the access still completes.
        run_txn(BUS_READ, 30'h0000300, 32'h0, 32'hCAFEF00D, 0, 2, 0, 2);
        // Stall held for three cycles at ready with the request still asserted.
        run_txn(BUS_READ, 30'h0000400, 32'h0, 32'h5A5AA5A5, 1, 0, 3, 0);

        // A flushed request in IDLE is suppressed.
        @(posedge clk); #1;
        req_access = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        req_access = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_no_req", {63'd0, bus_req_}, 64'd1);

        // Reset while the slave is still working.
        park = 1'b1;
        gdelay = 0;
        rdelay = 6;
        slave_data = 32'h77777777;
        sb_q.push_back('{a: 30'h0000500, r: BUS_READ, d: 32'h0});
        @(posedge clk); #1;
        req_access = 1'b1;
        rw = BUS_READ;
        addr = 30'h0000500;
        wr_data = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus_as_ == 1'b0) seen = 1'b1;
        end
        chk("rst_test_strobe_seen", {63'd0, seen}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        req_access = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_bus_req", {63'd0, bus_req_}, 64'd1);
        chk("midrst_bus_as", {63'd0, bus_as_}, 64'd1);
        chk("midrst_rd_data", {32'd0, rd_data}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        last_rd = '0;

        // Randomized accesses.
        for (int t = 0; t < 40; t++) begin
            logic              r_rw;
            logic [ADDR_W-1:0] r_addr;
            logic [DATA_W-1:0] r_wd;
            logic [DATA_W-1:0] r_rd;
            int gd, rdl, st, fl, sel;
            r_rw = 1'($urandom_range(0, 1));
            r_addr = ADDR_W'($urandom);
            r_wd = $urandom;
            r_rd = $urandom;
            gd = $urandom_range(0, 4);
            rdl = $urandom_range(0, 3);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            sel = $urandom_range(0, 6);
            fl = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
            if (fl == 1) begin
                gd = $urandom_range(2, 4);
                st = 0;
            end
            if (fl == 2 && rdl == 0) rdl = 1;
            run_txn(r_rw, r_addr, r_wd, r_rd, gd, rdl, st, fl);
        end

        repeat (3) @(negedge clk);
        chk("sb_strobe_empty", sb_q.size(), 0);
        chk("sb_ready_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
